// File: rtl/nv_nvdla_csc_issue_pkg.sv
// Shared types and constants for the CSC-to-CMAC issue sequencer.
package nv_nvdla_csc_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WT   = 2'd1,
    ST_DAT  = 2'd2,
    ST_DONE = 2'd3
  } issue_state_e;

  localparam int unsigned PD_W          = 9;
  localparam int unsigned PD_STRIPE_ST  = 0;
  localparam int unsigned PD_STRIPE_END = 1;
  localparam int unsigned PD_LAYER_END  = 2;
  localparam int unsigned PD_WT_FIRST   = 3;
  localparam int unsigned PD_STRIPE_LSB = 4;
  localparam int unsigned PD_STRIPE_W   = 5;

endpackage

// File: rtl/nv_nvdla_csc_mac_issue_ctrl_if.sv
// Upstream pop handshake plus the registered weight/data bus toward CMAC.
interface nv_nvdla_csc_mac_issue_ctrl_if
  import nv_nvdla_csc_issue_pkg::*;
#(
  parameter int unsigned ATOMK_HF = 8
);
  logic                wt_in_vld;
  logic                wt_in_pop;
  logic                dat_in_vld;
  logic                dat_in_pop;
  logic                sc2mac_wt_pvld;
  logic [ATOMK_HF-1:0] sc2mac_wt_sel;
  logic                sc2mac_dat_pvld;
  logic [PD_W-1:0]     sc2mac_dat_pd;

  // master: the issue sequencer; slave: upstream sources and CMAC side
  modport master (
    input  wt_in_vld, dat_in_vld,
    output wt_in_pop, dat_in_pop,
    output sc2mac_wt_pvld, sc2mac_wt_sel, sc2mac_dat_pvld, sc2mac_dat_pd
  );

  modport slave (
    output wt_in_vld, dat_in_vld,
    input  wt_in_pop, dat_in_pop,
    input  sc2mac_wt_pvld, sc2mac_wt_sel, sc2mac_dat_pvld, sc2mac_dat_pd
  );
endinterface

// File: rtl/nv_nvdla_csc_issue_cnt.sv
// Wrap counter: counts 0..last_val on inc, returns to 0 after last_val or on clr.
module nv_nvdla_csc_issue_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] cnt,
  output logic         is_last
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt     = cnt_q;
  assign is_last = (cnt_q == last_val);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = is_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/nv_nvdla_csc_mac_issue_ctrl.sv
// Stripe-level sequencer: loads weight kernels, then streams data atoms per stripe toward CMAC.
module nv_nvdla_csc_mac_issue_ctrl
  import nv_nvdla_csc_issue_pkg::*;
#(
  parameter int unsigned ATOMK_HF = 8,
  parameter int unsigned KW       = 3,
  parameter int unsigned LW       = 7,
  parameter int unsigned SW       = 13
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          op_start,
  input  logic [KW-1:0] cfg_kernels_m1,
  input  logic [LW-1:0] cfg_stripe_len_m1,
  input  logic [SW-1:0] cfg_stripes_m1,
  input  logic          cfg_wt_reuse,
  output logic          op_busy,
  output logic          op_done,
  nv_nvdla_csc_mac_issue_ctrl_if.master bus
);
  issue_state_e        state_q, state_d;
  logic [KW-1:0]       kern_m1_q, kern_m1_d;
  logic [LW-1:0]       len_m1_q, len_m1_d;
  logic [SW-1:0]       stripes_m1_q, stripes_m1_d;
  logic                reuse_q, reuse_d;
  logic                wt_first_q, wt_first_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wt_pvld_q, wt_pvld_d;
  logic [ATOMK_HF-1:0] sel_q, sel_d;
  logic                dat_pvld_q, dat_pvld_d;
  logic [PD_W-1:0]     pd_q, pd_d;

  logic          wt_pop, dat_pop, cnt_clr, s_inc;
  logic [KW-1:0] k_cnt;
  logic [LW-1:0] a_cnt;
  logic [SW-1:0] s_cnt;
  logic          k_last, a_last, s_last;

  nv_nvdla_csc_issue_cnt #(.W(KW)) u_k_cnt (
    .clk(nvdla_core_clk), .rst_n(nvdla_core_rstn), .clr(cnt_clr), .inc(wt_pop),
    .last_val(kern_m1_q), .cnt(k_cnt), .is_last(k_last)
  );

  nv_nvdla_csc_issue_cnt #(.W(LW)) u_a_cnt (
    .clk(nvdla_core_clk), .rst_n(nvdla_core_rstn), .clr(cnt_clr), .inc(dat_pop),
    .last_val(len_m1_q), .cnt(a_cnt), .is_last(a_last)
  );

  nv_nvdla_csc_issue_cnt #(.W(SW)) u_s_cnt (
    .clk(nvdla_core_clk), .rst_n(nvdla_core_rstn), .clr(cnt_clr), .inc(s_inc),
    .last_val(stripes_m1_q), .cnt(s_cnt), .is_last(s_last)
  );

  assign s_inc          = dat_pop & a_last;
  assign bus.wt_in_pop  = wt_pop;
  assign bus.dat_in_pop = dat_pop;

  // Next-state, pops and output-stage inputs
  always_comb begin
    state_d      = state_q;
    kern_m1_d    = kern_m1_q;
    len_m1_d     = len_m1_q;
    stripes_m1_d = stripes_m1_q;
    reuse_d      = reuse_q;
    wt_first_d   = wt_first_q;
    wt_pop       = 1'b0;
    dat_pop      = 1'b0;
    cnt_clr      = 1'b0;
    sel_d        = sel_q;
    pd_d         = pd_q;

    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          state_d      = ST_WT;
          kern_m1_d    = cfg_kernels_m1;
          len_m1_d     = cfg_stripe_len_m1;
          stripes_m1_d = cfg_stripes_m1;
          reuse_d      = cfg_wt_reuse;
          wt_first_d   = 1'b0;
          cnt_clr      = 1'b1;
        end
      end
      ST_WT: begin
        wt_pop = bus.wt_in_vld;
        if (wt_pop && k_last) begin
          state_d    = ST_DAT;
          wt_first_d = 1'b1;
        end
      end
      ST_DAT: begin
        dat_pop = bus.dat_in_vld;
        if (dat_pop) begin
          wt_first_d = 1'b0;
          if (a_last) begin
            if (s_last)       state_d = ST_DONE;
            else if (reuse_q) state_d = ST_DAT;
            else              state_d = ST_WT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // sel/pd hold their last value across bubbles
    wt_pvld_d  = wt_pop;
    dat_pvld_d = dat_pop;
    if (wt_pop) begin
      sel_d = ATOMK_HF'(1) << k_cnt;
    end
    if (dat_pop) begin
      pd_d[PD_STRIPE_ST]                    = (a_cnt == '0);
      pd_d[PD_STRIPE_END]                   = a_last;
      pd_d[PD_LAYER_END]                    = a_last & s_last;
      pd_d[PD_WT_FIRST]                     = wt_first_q;
      pd_d[PD_STRIPE_LSB +: PD_STRIPE_W]    = PD_STRIPE_W'(s_cnt);
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= ST_IDLE;
      kern_m1_q    <= '0;
      len_m1_q     <= '0;
      stripes_m1_q <= '0;
      reuse_q      <= 1'b0;
      wt_first_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wt_pvld_q    <= 1'b0;
      sel_q        <= '0;
      dat_pvld_q   <= 1'b0;
      pd_q         <= '0;
    end else begin
      state_q      <= state_d;
      kern_m1_q    <= kern_m1_d;
      len_m1_q     <= len_m1_d;
      stripes_m1_q <= stripes_m1_d;
      reuse_q      <= reuse_d;
      wt_first_q   <= wt_first_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wt_pvld_q    <= wt_pvld_d;
      sel_q        <= sel_d;
      dat_pvld_q   <= dat_pvld_d;
      pd_q         <= pd_d;
    end
  end

  assign op_busy             = busy_q;
  assign op_done             = done_q;
  assign bus.sc2mac_wt_pvld  = wt_pvld_q;
  assign bus.sc2mac_wt_sel   = sel_q;
  assign bus.sc2mac_dat_pvld = dat_pvld_q;
  assign bus.sc2mac_dat_pd   = pd_q;
endmodule

// File: tb/tb_nv_nvdla_csc_mac_issue_ctrl.sv
// Scoreboard bench: a stripe/kernel/atom loop model predicts the ordered CMAC stream.
module tb_nv_nvdla_csc_mac_issue_ctrl;
  localparam int unsigned ATOMK_HF = 8;
  localparam int unsigned KW = 3;
  localparam int unsigned LW = 7;
  localparam int unsigned SW = 13;

  typedef struct {
    bit         is_wt;
    logic [8:0] val;
    int         cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_start = 1'b0;
  logic [KW-1:0] cfg_kernels_m1 = '0;
  logic [LW-1:0] cfg_stripe_len_m1 = '0;
  logic [SW-1:0] cfg_stripes_m1 = '0;
  logic          cfg_wt_reuse = 1'b0;
  logic          op_busy, op_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   vmode   = 0;
  exp_t sb[$];
  bit   prev_wt_pop  = 1'b0;
  bit   prev_dat_pop = 1'b0;

  nv_nvdla_csc_mac_issue_ctrl_if #(.ATOMK_HF(ATOMK_HF)) bus ();

  nv_nvdla_csc_mac_issue_ctrl #(
    .ATOMK_HF(ATOMK_HF), .KW(KW), .LW(LW), .SW(SW)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rst_n),
    .op_start         (op_start),
    .cfg_kernels_m1   (cfg_kernels_m1),
    .cfg_stripe_len_m1(cfg_stripe_len_m1),
    .cfg_stripes_m1   (cfg_stripes_m1),
    .cfg_wt_reuse     (cfg_wt_reuse),
    .op_busy          (op_busy),
    .op_done          (op_done),
    .bus              (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, got, want);
    end
  endfunction

  // Upstream valid patterns: 0 = always available, 1 = random, 2 = data toggling
  always @(posedge clk) begin
    #1;
    case (vmode)
      0: begin bus.wt_in_vld = 1'b1; bus.dat_in_vld = 1'b1; end
      1: begin bus.wt_in_vld = 1'($urandom_range(1)); bus.dat_in_vld = 1'($urandom_range(1)); end
      default: begin bus.wt_in_vld = 1'b1; bus.dat_in_vld = ~bus.dat_in_vld; end
    endcase
  end

  // Reference: every stripe loads weights unless reused, then streams len atoms
  function automatic void push_op(int k, int l, int s, bit reuse, int base);
    exp_t e;
    int   idx;
    bit   load;
    idx = 0;
    for (int st = 0; st <= s; st++) begin
      load = (st == 0) || !reuse;
      if (load) begin
        for (int kk = 0; kk <= k; kk++) begin
          e.is_wt = 1'b1;
          e.val   = 9'(1 << kk);
          e.cyc   = (base < 0) ? -1 : base + idx;
          sb.push_back(e);
          idx++;
        end
      end
      for (int a = 0; a <= l; a++) begin
        e.is_wt = 1'b0;
        e.val   = 9'((st % 32) * 16 + ((load && a == 0) ? 8 : 0)
                     + ((a == l && st == s) ? 4 : 0) + ((a == l) ? 2 : 0) + ((a == 0) ? 1 : 0));
        e.cyc   = (base < 0) ? -1 : base + idx;
        sb.push_back(e);
        idx++;
      end
    end
  endfunction

  // Monitor: pops the scoreboard whenever CMAC sees a valid atom
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_wt_pop  = 1'b0;
      prev_dat_pop = 1'b0;
    end else begin
      if (prev_wt_pop || bus.sc2mac_wt_pvld) chk("wt_pvld_lat", int'(bus.sc2mac_wt_pvld), int'(prev_wt_pop));
      if (prev_dat_pop || bus.sc2mac_dat_pvld) chk("dat_pvld_lat", int'(bus.sc2mac_dat_pvld), int'(prev_dat_pop));
      if (bus.wt_in_pop) chk("wt_pop_vld", int'(bus.wt_in_vld), 1);
      if (bus.dat_in_pop) chk("dat_pop_vld", int'(bus.dat_in_vld), 1);
      if (bus.wt_in_pop && bus.dat_in_pop) chk("pop_excl", 1, 0);
      if (bus.sc2mac_wt_pvld || bus.sc2mac_dat_pvld) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("kind_is_wt", int'(bus.sc2mac_wt_pvld), int'(e.is_wt));
          if (e.is_wt) chk("wt_sel", int'(bus.sc2mac_wt_sel), int'(e.val));
          else         chk("dat_pd", int'(bus.sc2mac_dat_pd), int'(e.val));
          if (e.cyc >= 0) chk("out_cycle", cyc, e.cyc);
        end
      end
      if (op_done || (bus.sc2mac_dat_pvld && bus.sc2mac_dat_pd[2]))
        chk("done_align", int'(op_done), int'(bus.sc2mac_dat_pvld && bus.sc2mac_dat_pd[2]));
      prev_wt_pop  = bus.wt_in_pop;
      prev_dat_pop = bus.dat_in_pop;
    end
  end

  task automatic start_op(input int k, input int l, input int s, input bit reuse);
    @(posedge clk); #1;
    cfg_kernels_m1    = KW'(k);
    cfg_stripe_len_m1 = LW'(l);
    cfg_stripes_m1    = SW'(s);
    cfg_wt_reuse      = reuse;
    op_start          = 1'b1;
    push_op(k, l, s, reuse, (vmode == 0) ? cyc + 2 : -1);
    @(negedge clk);
    chk("busy_before", int'(op_busy), 0);
  endtask

  // Spurious starts and config churn while busy must not disturb the operation
  task automatic wait_done(input int spur_pct);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      op_start          = ($urandom_range(99) < spur_pct);
      cfg_kernels_m1    = KW'($urandom);
      cfg_stripe_len_m1 = LW'($urandom);
      cfg_stripes_m1    = SW'($urandom);
      cfg_wt_reuse      = 1'($urandom);
      @(negedge clk);
      if (i == 0) chk("busy_after_start", int'(op_busy), 1);
      if (op_done) begin
        seen = 1'b1;
        chk("busy_in_done", int'(op_busy), 1);
      end
    end
    chk("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    op_start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", int'(op_busy), 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_op(input int k, input int l, input int s, input bit reuse, input int spur);
    start_op(k, l, s, reuse);
    wait_done(spur);
  endtask

  function automatic int out_vec();
    return int'({op_busy, op_done, bus.wt_in_pop, bus.dat_in_pop, bus.sc2mac_wt_pvld,
                 bus.sc2mac_wt_sel, bus.sc2mac_dat_pvld, bus.sc2mac_dat_pd});
  endfunction

  initial begin
    bus.wt_in_vld  = 1'b0;
    bus.dat_in_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vmode = 0;
    run_op(2, 3, 0, 1'b0, 0);    // basic
    run_op(2, 3, 2, 1'b1, 0);    // weight reuse
    run_op(2, 3, 2, 1'b0, 0);    // reload every stripe
    vmode = 2;
    run_op(1, 0, 3, 1'b0, 0);    // data starvation, single-atom stripes
    vmode = 0;
    run_op(2, 3, 1, 1'b0, 100);  // start held high through DAT and DONE

    // Abort mid weight load
    start_op(7, 3, 1, 1'b0);
    op_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_outputs", out_vec(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(7, 2, 0, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      vmode = int'($urandom_range(2));
      run_op(int'($urandom_range(7)), int'($urandom_range(5)), int'($urandom_range(3)),
             1'($urandom), 20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nv_nvdla_csc_mac_issue_ctrl.md
# nv_nvdla_csc_mac_issue_ctrl

Stripe-level issue sequencer that drives the CSC-to-CMAC weight/data interface ahead of the csc2cmac retiming stage. Per operation it runs a configurable number of stripes. Each stripe loads a weight kernel set, one-hot `sel` per kernel, then streams the stripe's data atoms with sideband `pd` flags. Weights can be reused across stripes. It pops atoms from upstream weight and data sources and generates registered `pvld`/`sel`/`pd` toward CMAC. CMAC has no back-pressure, so every issued atom is final.

## Interface
Parameters:
- ATOMK_HF, 8: kernels per weight load; width of `sel`.
- KW, 3: width of `cfg_kernels_m1` (must be ≥ clog2(ATOMK_HF)).
- LW, 7: width of `cfg_stripe_len_m1`.
- SW, 13: width of `cfg_stripes_m1`.

Ports:
- Clock/reset (already decided): one clock, `nvdla_core_clk`; reset `nvdla_core_rstn` is asynchronous and active-low.
- `nvdla_core_clk`  in  1  core clock.
- `nvdla_core_rstn`  in  1  async active-low reset.
- `op_start`  in  1  single-cycle start pulse; sampled only in IDLE.
- `cfg_kernels_m1`  in  KW  kernels per load minus 1; valid range 0..ATOMK_HF-1.
- `cfg_stripe_len_m1`  in  LW  data atoms per stripe minus 1.
- `cfg_stripes_m1`  in  SW  stripes per operation minus 1.
- `cfg_wt_reuse`  in  1  1 = load weights for the first stripe only.
- `op_busy`  out  1  high from the cycle after an accepted start through the DONE state.
- `op_done`  out  1  one-cycle pulse in the DONE state.
- `wt_in_vld`  in  1  upstream weight atom available.
- `wt_in_pop`  out  1  combinational; consumes one weight atom.
- `dat_in_vld`  in  1  upstream data atom available.
- `dat_in_pop`  out  1  combinational; consumes one data atom.
- `sc2mac_wt_pvld`  out  1  registered weight valid.
- `sc2mac_wt_sel`  out  ATOMK_HF  registered one-hot kernel select.
- `sc2mac_dat_pvld`  out  1  registered data valid.
- `sc2mac_dat_pd`  out  9  registered data sideband.

## Operation
- Config is captured into shadow registers on an accepted `op_start`. Config inputs are ignored after capture.
- FSM states: IDLE, WT, DAT, DONE.
  - IDLE → WT on `op_start`.
  - WT → DAT after the last kernel pop.
  - DAT → WT after the last atom of a stripe, if more stripes remain and reuse=0.
  - DAT → DAT (next stripe) after the last atom, if more stripes remain and reuse=1.
  - DAT → DONE after the last atom of the last stripe.
  - DONE → IDLE unconditionally after 1 cycle.
- `op_start` while not IDLE is ignored. This includes the DONE cycle.
- WT state:
  - `wt_in_pop = wt_in_vld`.
  - Kernel counter k counts 0..cfg_kernels_m1 and advances on pop.
  - `sc2mac_wt_sel` = one-hot(k) for that pop.
- DAT state:
  - `dat_in_pop = dat_in_vld`.
  - Atom counter a counts 0..cfg_stripe_len_m1.
  - Stripe counter s counts 0..cfg_stripes_m1 and increments when a wraps.
- Pops are mutually exclusive; both pops are 0 outside WT/DAT.
- `pd` layout (data atom):
  - [0] stripe_st: a==0.
  - [1] stripe_end: a==len_m1.
  - [2] layer_end: stripe_end && s==stripes_m1.
  - [3] wt_first: first data atom after a weight load.
  - [8:4] s[4:0].
- A single-atom stripe sets stripe_st and stripe_end together.
- Upstream starvation (vld=0) inserts bubbles. Counters hold and outputs deassert `pvld`. Bubbles never corrupt ordering.
- `sel` and `pd` hold their last value when the corresponding `pvld`=0.

## Timing
- Pop at cycle N → corresponding `pvld`/`sel`/`pd` at N+1.
- `op_start` at cycle N → WT at N+1. The earliest weight pop is at N+1, so the earliest `sc2mac_wt_pvld` is at N+2.
- WT/DAT turnaround is zero bubble: the first dat pop can occur the cycle after the last wt pop. DAT→WT is likewise zero bubble.
- `op_done` is asserted in the cycle `sc2mac_dat_pvld` carries layer_end. IDLE follows one cycle later.
- Throughput: one atom per cycle with continuous `vld`.
- Reset values: all outputs 0. FSM=IDLE; counters and shadow config=0.
- Async reset mid-operation aborts immediately. No partial `done` is generated, and upstream atoms already popped are discarded.

## Structure
- Shared package `nv_nvdla_csc_issue_pkg`:
  - FSM state encoding (2-bit).
  - `pd` bit-position constants: PD_STRIPE_ST=0, PD_STRIPE_END=1, PD_LAYER_END=2, PD_WT_FIRST=3, PD_STRIPE_LSB=4.
- One natural sub-module, `nv_nvdla_csc_issue_cnt`: a parameterised wrap counter with inc/clr inputs and an is_last output. It is instantiated for k, a and s.
- The output register stage is in the top module.

## Test plan
- Basic: kernels_m1=2, len_m1=3, stripes_m1=0, vld tied 1.
  - `wt_sel` 0x01, 0x02, 0x04 at N+2..N+4.
  - Dat `pd` 0x009, 0x000, 0x000, 0x006 at N+5..N+8.
  - `op_done` at N+8.
- Reuse: stripes_m1=2 with cfg_wt_reuse=1.
  - Exactly one WT burst.
  - Stripe-2 last atom `pd` = 0x026; `wt_first` only on the very first atom.
- No reuse, same config as Reuse: three WT bursts, each followed by a `pd[3]`=1 atom. Zero bubbles between phases.
- Starvation: toggle `dat_in_vld` 1010…, len_m1=0.
  - Each `pvld` follows its pop by 1 cycle.
  - Every atom has `pd[1:0]`=11.
- Start while busy: a second `op_start` mid-DAT and in DONE is ignored. Counts and `op_done` are unchanged.
- Reset mid-WT: all outputs 0 on the next edge. A fresh `op_start` afterwards produces sel 0x01 first.
